// File: rtl/plab5_mcore_dma_engine.sv
// Word-by-word DMA copy engine behind the checker command port, plus single-word debug reads.
// Define DMA_DOMAIN_CHECK_EN to reject domain-0 accesses that touch the secure region.
module plab5_mcore_dma_engine #(
    parameter int                      p_opaque_nbits = 8,
    parameter int                      p_addr_nbits   = 32,
    parameter int                      p_data_nbits   = 32,
    parameter int                      p_xfer_words   = 4,
    parameter logic [p_addr_nbits-1:0] p_secure_base  = 'h0000_8000
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    dma_val,
    output logic                                    dma_rdy,
    input  logic                                    dma_domain,
    input  logic [p_addr_nbits-1:0]                 dma_src_addr,
    input  logic [p_addr_nbits-1:0]                 dma_dest_addr,
    input  logic [3+p_opaque_nbits+p_addr_nbits+1:0] dma_req_control,
    input  logic                                    dma_inst,
    output logic                                    dma_ack,
    output logic                                    dma_resp_domain,
    output logic [3+p_opaque_nbits+1:0]             dma_resp_control,
    input  logic                                    dma_db_val,
    input  logic                                    dma_db_domain,
    input  logic [p_addr_nbits-1:0]                 dma_db_src_addr,
    input  logic [p_addr_nbits-1:0]                 dma_db_dest_addr,
    input  logic                                    dma_db_inst,
    output logic [p_data_nbits-1:0]                 dma_db_debug_data,
    output logic                                    mem_req_val,
    input  logic                                    mem_req_rdy,
    output logic                                    mem_req_type,
    output logic [p_addr_nbits-1:0]                 mem_req_addr,
    output logic [p_data_nbits-1:0]                 mem_req_data,
    input  logic                                    mem_resp_val,
    output logic                                    mem_resp_rdy,
    input  logic [p_data_nbits-1:0]                 mem_resp_data
);

    localparam int CTRL_W = 3 + p_opaque_nbits + p_addr_nbits + 2;
    localparam int CW     = $clog2(p_xfer_words) + 1;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] RD_REQ  = 4'd1;
    localparam logic [3:0] RD_WAIT = 4'd2;
    localparam logic [3:0] WR_REQ  = 4'd3;
    localparam logic [3:0] WR_WAIT = 4'd4;
    localparam logic [3:0] ACK     = 4'd5;
    localparam logic [3:0] DB_REQ  = 4'd6;
    localparam logic [3:0] DB_WAIT = 4'd7;
    localparam logic [3:0] DB_ACK  = 4'd8;
`ifdef DMA_DOMAIN_CHECK_EN
    localparam logic [3:0] CHECK   = 4'd9;

    // True when any word of a p_xfer_words burst starting at base lands in the secure region.
    function automatic logic span_secure(input logic [p_addr_nbits-1:0] base);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < p_xfer_words; k++)
            if (base + p_addr_nbits'(4 * k) >= p_secure_base) hit = 1'b1;
        return hit;
    endfunction
`endif

    logic [3:0]              state_q,   state_d;
    logic [CW-1:0]           cnt_q,     cnt_d;
    logic                    dom_q,     dom_d;
    logic [p_addr_nbits-1:0] src_q,     src_d;
    logic [p_addr_nbits-1:0] dest_q,    dest_d;
    logic [CTRL_W-1:0]       ctrl_q,    ctrl_d;
    logic                    inst_q,    inst_d;
    logic                    db_dom_q,  db_dom_d;
    logic [p_addr_nbits-1:0] db_src_q,  db_src_d;
    logic [p_addr_nbits-1:0] db_dest_q, db_dest_d;
    logic                    db_inst_q, db_inst_d;
    logic [p_data_nbits-1:0] buf_q,     buf_d;
    logic                    err_q,     err_d;
    logic [p_addr_nbits-1:0] word_off;

    assign word_off     = p_addr_nbits'(cnt_q) << 2;
    assign dma_rdy      = reset && (state_q == IDLE);
    assign mem_resp_rdy = reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dom_d     = dom_q;
        src_d     = src_q;
        dest_d    = dest_q;
        ctrl_d    = ctrl_q;
        inst_d    = inst_q;
        db_dom_d  = db_dom_q;
        db_src_d  = db_src_q;
        db_dest_d = db_dest_q;
        db_inst_d = db_inst_q;
        buf_d     = buf_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                // The NoC command wins a tie; the debug command is left untouched and must be held.
                if (dma_val) begin
                    dom_d  = dma_domain;
                    src_d  = dma_src_addr;
                    dest_d = dma_dest_addr;
                    ctrl_d = dma_req_control;
                    inst_d = dma_inst;
                    cnt_d  = '0;
                    err_d  = 1'b0;
`ifdef DMA_DOMAIN_CHECK_EN
                    state_d = CHECK;
`else
                    state_d = RD_REQ;
`endif
                end else if (dma_db_val) begin
                    db_dom_d  = dma_db_domain;
                    db_src_d  = dma_db_src_addr;
                    db_dest_d = dma_db_dest_addr;
                    db_inst_d = dma_db_inst;
                    state_d   = DB_REQ;
`ifdef DMA_DOMAIN_CHECK_EN
                    if (!dma_db_domain && (dma_db_src_addr >= p_secure_base)) begin
                        buf_d   = '0;
                        state_d = DB_ACK;
                    end
`endif
                end
            end
`ifdef DMA_DOMAIN_CHECK_EN
            CHECK: begin
                if (!dom_q && (span_secure(src_q) || span_secure(dest_q))) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    state_d = RD_REQ;
                end
            end
`endif
            RD_REQ:  if (mem_req_rdy) state_d = RD_WAIT;
            RD_WAIT: if (mem_resp_val) begin
                buf_d   = mem_resp_data;
                state_d = WR_REQ;
            end
            WR_REQ:  if (mem_req_rdy) state_d = WR_WAIT;
            WR_WAIT: if (mem_resp_val) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(p_xfer_words - 1)) ? ACK : RD_REQ;
            end
            ACK: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            DB_REQ:  if (mem_req_rdy) state_d = DB_WAIT;
            DB_WAIT: if (mem_resp_val) begin
                buf_d   = mem_resp_data;
                state_d = DB_ACK;
            end
            DB_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dom_q     <= 1'b0;
            src_q     <= '0;
            dest_q    <= '0;
            ctrl_q    <= '0;
            inst_q    <= 1'b0;
            db_dom_q  <= 1'b0;
            db_src_q  <= '0;
            db_dest_q <= '0;
            db_inst_q <= 1'b0;
            buf_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dom_q     <= dom_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            ctrl_q    <= ctrl_d;
            inst_q    <= inst_d;
            db_dom_q  <= db_dom_d;
            db_src_q  <= db_src_d;
            db_dest_q <= db_dest_d;
            db_inst_q <= db_inst_d;
            buf_q     <= buf_d;
            err_q     <= err_d;
        end
    end

    // Every output is decoded from state alone, so the async reset zeroes them at once.
    always_comb begin
        mem_req_val       = 1'b0;
        mem_req_type      = 1'b0;
        mem_req_addr      = '0;
        mem_req_data      = '0;
        dma_ack           = 1'b0;
        dma_resp_domain   = 1'b0;
        dma_resp_control  = '0;
        dma_db_debug_data = '0;
        case (state_q)
            RD_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_addr = src_q + word_off;
            end
            WR_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_type = 1'b1;
                mem_req_addr = dest_q + word_off;
                mem_req_data = buf_q;
            end
            DB_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_addr = db_src_q;
            end
            ACK: begin
                dma_ack          = 1'b1;
                dma_resp_domain  = dom_q;
                dma_resp_control = {err_q ? 3'd7 : ctrl_q[CTRL_W-1 -: 3],
                                    ctrl_q[CTRL_W-4 -: p_opaque_nbits], 2'b00};
            end
            DB_ACK: begin
                dma_resp_domain   = db_dom_q;
                dma_db_debug_data = buf_q;
            end
            default: ;
        endcase
    end

    // Latched-only fields: command address/len, instruction codes and the debug destination.
    logic unused_sink;
`ifdef DMA_DOMAIN_CHECK_EN
    assign unused_sink = ^{inst_q, db_inst_q, db_dest_q, ctrl_q[p_addr_nbits+1:0]};
`else
    assign unused_sink = ^{inst_q, db_inst_q, db_dest_q, ctrl_q[p_addr_nbits+1:0], p_secure_base};
`endif

endmodule

// File: tb/tb_plab5_mcore_dma_engine.sv
// Scoreboard bench for plab5_mcore_dma_engine: a memory responder logs requests and acks,
// each test task compares the logs against expectations queued when its commands were issued.
module tb_plab5_mcore_dma_engine;
    localparam int O      = 8;
    localparam int A      = 32;
    localparam int D      = 32;
    localparam int N      = 4;
    localparam int CTRL_W = 3 + O + A + 2;
    localparam int RESP_W = 3 + O + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              dma_val, dma_rdy, dma_domain, dma_inst, dma_ack, dma_resp_domain;
    logic [A-1:0]      dma_src_addr, dma_dest_addr;
    logic [CTRL_W-1:0] dma_req_control;
    logic [RESP_W-1:0] dma_resp_control;
    logic              dma_db_val, dma_db_domain, dma_db_inst;
    logic [A-1:0]      dma_db_src_addr, dma_db_dest_addr;
    logic [D-1:0]      dma_db_debug_data;
    logic              mem_req_val, mem_req_rdy, mem_req_type, mem_resp_val, mem_resp_rdy;
    logic [A-1:0]      mem_req_addr;
    logic [D-1:0]      mem_req_data, mem_resp_data;

    always #5 clk = ~clk;

    plab5_mcore_dma_engine #(
        .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D),
        .p_xfer_words(N), .p_secure_base(32'h0000_8000)
    ) dut (
        .clk(clk), .reset(reset),
        .dma_val(dma_val), .dma_rdy(dma_rdy), .dma_domain(dma_domain),
        .dma_src_addr(dma_src_addr), .dma_dest_addr(dma_dest_addr),
        .dma_req_control(dma_req_control), .dma_inst(dma_inst),
        .dma_ack(dma_ack), .dma_resp_domain(dma_resp_domain), .dma_resp_control(dma_resp_control),
        .dma_db_val(dma_db_val), .dma_db_domain(dma_db_domain),
        .dma_db_src_addr(dma_db_src_addr), .dma_db_dest_addr(dma_db_dest_addr),
        .dma_db_inst(dma_db_inst), .dma_db_debug_data(dma_db_debug_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_type(mem_req_type),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data)
    );

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;
    int stall_n   = 0;
    int n_wr      = 0;
    int stab_err  = 0;
    int pulse_err = 0;

    logic [64:0]     exp_req[$];
    logic [64:0]     req_obs[$];
    logic [RESP_W:0] exp_ack[$];
    logic [RESP_W:0] ack_obs[$];
    int              ack_cyc[$];
    logic [D-1:0]    dbg_obs[$];
    int              dbg_cyc[$];
    logic [D-1:0]    mem[logic [A-1:0]];
    logic [D-1:0]    ref_mem[logic [A-1:0]];

    function automatic logic [D-1:0] rd_mem(input logic [A-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    function automatic logic [D-1:0] rd_ref(input logic [A-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Memory responder: decides rdy at the falling edge, answers one cycle after each handshake.
    logic         pend = 1'b0;
    logic [D-1:0] pend_data = '0;
    logic         prev_hold = 1'b0;
    logic         last_ack = 1'b0;
    logic [64:0]  prev_req = '0;
    int           wait_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
            pend = 1'b0; prev_hold = 1'b0; wait_cnt = 0; last_ack = 1'b0;
        end else begin
            mem_resp_val = 1'b0; mem_resp_data = '0;
            if (pend) begin
                mem_resp_val = 1'b1; mem_resp_data = pend_data; pend = 1'b0;
            end
            if (dma_ack) begin
                if (last_ack) pulse_err++;
                ack_obs.push_back({dma_resp_domain, dma_resp_control});
                ack_cyc.push_back(cyc);
            end
            last_ack = dma_ack;
            if (dma_resp_domain && !dma_ack) begin
                dbg_obs.push_back(dma_db_debug_data);
                dbg_cyc.push_back(cyc);
            end
            if (mem_req_val) begin
                if (prev_hold && ({mem_req_type, mem_req_addr, mem_req_data} !== prev_req)) stab_err++;
                prev_req = {mem_req_type, mem_req_addr, mem_req_data};
                if (wait_cnt < stall_n) begin
                    mem_req_rdy = 1'b0; wait_cnt++; prev_hold = 1'b1;
                end else begin
                    mem_req_rdy = 1'b1; wait_cnt = 0; prev_hold = 1'b0;
                    req_obs.push_back({mem_req_type, mem_req_addr, mem_req_data});
                    if (mem_req_type) begin
                        mem[mem_req_addr] = mem_req_data; pend_data = '0; n_wr++;
                    end else begin
                        pend_data = rd_mem(mem_req_addr);
                    end
                    pend = 1'b1;
                end
            end else begin
                mem_req_rdy = 1'b0; prev_hold = 1'b0; wait_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic preload(input logic [A-1:0] a, input logic [D-1:0] v);
        mem[a] = v; ref_mem[a] = v;
    endtask

    task automatic clear_logs();
        exp_req.delete(); req_obs.delete(); exp_ack.delete(); ack_obs.delete();
        ack_cyc.delete(); dbg_obs.delete(); dbg_cyc.delete();
        stab_err = 0; pulse_err = 0;
    endtask

    // Drives one NoC command once the engine is idle and queues the traffic it should cause.
    task automatic issue_noc(input logic dom, input logic [A-1:0] src, input logic [A-1:0] dest,
                             input logic [2:0] typ, input logic [O-1:0] opq, input logic err);
        logic [A-1:0] a_s, a_d;
        logic [D-1:0] v;
        for (int i = 0; i < 500; i++) begin
            if (dma_rdy) break;
            step(1);
        end
        if (!err) begin
            for (int k = 0; k < N; k++) begin
                a_s = src + A'(4 * k);
                a_d = dest + A'(4 * k);
                v   = rd_ref(a_s);
                exp_req.push_back({1'b0, a_s, 32'h0});
                exp_req.push_back({1'b1, a_d, v});
                ref_mem[a_d] = v;
            end
        end
        exp_ack.push_back({dom, err ? 3'd7 : typ, opq, 2'b00});
        dma_val = 1'b1; dma_domain = dom; dma_src_addr = src; dma_dest_addr = dest;
        dma_req_control = {typ, opq, src, 2'b11}; dma_inst = 1'b0;
        step(1);
        dma_val = 1'b0;
    endtask

    task automatic wait_acks(input int n);
        for (int i = 0; i < 2000; i++) begin
            if (ack_obs.size() >= n) break;
            step(1);
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({dma_rdy, dma_ack, mem_req_val, mem_resp_rdy, dma_resp_domain, mem_req_type} !== 6'b0) begin
            failed++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {dma_rdy, dma_ack, mem_req_val, mem_resp_rdy, dma_resp_domain, mem_req_type});
        end
        tests_run++;
        if ({mem_req_addr, mem_req_data, dma_resp_control, dma_db_debug_data} !== '0) begin
            failed++;
            $display("FAIL reset_data: got addr=%h data=%h ctrl=%h dbg=%h expected all 0",
                     mem_req_addr, mem_req_data, dma_resp_control, dma_db_debug_data);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({dma_rdy, mem_resp_rdy} !== 2'b11) begin
            failed++;
            $display("FAIL reset_release: got rdy/resp_rdy=%b expected 11", {dma_rdy, mem_resp_rdy});
        end
    endtask

    task automatic test_noc_copy();
        logic [64:0] e, o;
        logic [RESP_W:0] ea, oa;
        clear_logs();
        for (int k = 0; k < N; k++) preload(32'h100 + 32'(4 * k), 32'(k + 1));
        issue_noc(1'b1, 32'h100, 32'h200, 3'd1, 8'h5A, 1'b0);
        wait_acks(1);
        step(6);
        tests_run++;
        if (req_obs.size() != exp_req.size()) begin
            failed++;
            $display("FAIL copy_req_count: got %0d expected %0d", req_obs.size(), exp_req.size());
        end
        while (exp_req.size() > 0 && req_obs.size() > 0) begin
            e = exp_req.pop_front(); o = req_obs.pop_front();
            tests_run++;
            if (o !== e) begin failed++; $display("FAIL copy_req: got %h expected %h", o, e); end
        end
        tests_run++;
        if (ack_obs.size() != 1 || pulse_err != 0) begin
            failed++;
            $display("FAIL copy_ack_count: got %0d acks (%0d long) expected 1", ack_obs.size(), pulse_err);
        end
        if (ack_obs.size() > 0) begin
            ea = exp_ack.pop_front(); oa = ack_obs.pop_front();
            tests_run++;
            if (oa !== ea) begin failed++; $display("FAIL copy_ack: got %h expected %h", oa, ea); end
        end
        for (int k = 0; k < N; k++) begin
            tests_run++;
            if (rd_mem(32'h200 + 32'(4 * k)) !== 32'(k + 1)) begin
                failed++;
                $display("FAIL copy_mem[%0d]: got %h expected %h", k, rd_mem(32'h200 + 32'(4 * k)), k + 1);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [64:0] e, o;
        logic [RESP_W:0] ea, oa;
        clear_logs();
        dma_db_val = 1'b1; dma_db_domain = 1'b1; dma_db_src_addr = 32'h100;
        dma_db_dest_addr = 32'h0; dma_db_inst = 1'b0;
        issue_noc(1'b0, 32'h100, 32'h400, 3'd2, 8'h11, 1'b0);
        exp_req.push_back({1'b0, 32'h100, 32'h0});
        for (int i = 0; i < 500; i++) begin
            if (dma_rdy) break;
            step(1);
        end
        step(1);
        dma_db_val = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dbg_obs.size() > 0) break;
            step(1);
        end
        step(4);
        tests_run++;
        if (ack_obs.size() != 1 || dbg_obs.size() != 1) begin
            failed++;
            $display("FAIL sim_counts: got acks=%0d dbg=%0d expected 1 and 1", ack_obs.size(), dbg_obs.size());
        end else begin
            tests_run++;
            if (!(ack_cyc[0] < dbg_cyc[0])) begin
                failed++;
                $display("FAIL sim_order: got ack cycle %0d dbg cycle %0d expected ack first", ack_cyc[0], dbg_cyc[0]);
            end
            ea = exp_ack.pop_front(); oa = ack_obs.pop_front();
            tests_run++;
            if (oa !== ea) begin failed++; $display("FAIL sim_ack: got %h expected %h", oa, ea); end
            tests_run++;
            if (dbg_obs[0] !== 32'h1) begin
                failed++;
                $display("FAIL sim_dbg_data: got %h expected 00000001", dbg_obs[0]);
            end
        end
        tests_run++;
        if (req_obs.size() != exp_req.size()) begin
            failed++;
            $display("FAIL sim_req_count: got %0d expected %0d", req_obs.size(), exp_req.size());
        end
        while (exp_req.size() > 0 && req_obs.size() > 0) begin
            e = exp_req.pop_front(); o = req_obs.pop_front();
            tests_run++;
            if (o !== e) begin failed++; $display("FAIL sim_req: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] e, o;
        int rdy_hi;
        clear_logs();
        for (int k = 0; k < N; k++) preload(32'h500 + 32'(4 * k), 32'h11 * 32'(k + 1));
        stall_n = 3;
        rdy_hi = 0;
        issue_noc(1'b1, 32'h500, 32'h600, 3'd1, 8'h33, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (ack_obs.size() >= 1) break;
            if (dma_rdy) rdy_hi++;
            step(1);
        end
        step(6);
        stall_n = 0;
        tests_run++;
        if (rdy_hi != 0) begin failed++; $display("FAIL bp_rdy_busy: got %0d cycles high expected 0", rdy_hi); end
        tests_run++;
        if (stab_err != 0) begin failed++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err); end
        tests_run++;
        if (req_obs.size() != 2 * N || ack_obs.size() != 1) begin
            failed++;
            $display("FAIL bp_counts: got reqs=%0d acks=%0d expected %0d and 1", req_obs.size(), ack_obs.size(), 2 * N);
        end
        while (exp_req.size() > 0 && req_obs.size() > 0) begin
            e = exp_req.pop_front(); o = req_obs.pop_front();
            tests_run++;
            if (o !== e) begin failed++; $display("FAIL bp_req: got %h expected %h", o, e); end
        end
        for (int k = 0; k < N; k++) begin
            tests_run++;
            if (rd_mem(32'h600 + 32'(4 * k)) !== 32'h11 * 32'(k + 1)) begin
                failed++;
                $display("FAIL bp_mem[%0d]: got %h expected %h", k, rd_mem(32'h600 + 32'(4 * k)), 32'h11 * (k + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] e, o;
        logic [RESP_W:0] ea, oa;
        int base_wr, base_req;
        clear_logs();
        for (int k = 0; k < N; k++) preload(32'h700 + 32'(4 * k), 32'hA0 + 32'(k));
        base_wr = n_wr;
        issue_noc(1'b1, 32'h700, 32'h800, 3'd1, 8'h44, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (n_wr - base_wr >= 3) break;
            step(1);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({dma_rdy, dma_ack, mem_req_val, mem_resp_rdy, dma_resp_domain, mem_req_addr, mem_req_data} !== '0) begin
            failed++;
            $display("FAIL midreset_outputs: got rdy=%b ack=%b val=%b resp_rdy=%b addr=%h expected all 0",
                     dma_rdy, dma_ack, mem_req_val, mem_resp_rdy, mem_req_addr);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        base_req = req_obs.size();
        step(20);
        tests_run++;
        if (req_obs.size() != base_req || ack_obs.size() != 0) begin
            failed++;
            $display("FAIL midreset_quiet: got %0d new reqs %0d acks expected 0 and 0",
                     req_obs.size() - base_req, ack_obs.size());
        end
        clear_logs();
        issue_noc(1'b0, 32'h700, 32'h900, 3'd3, 8'h22, 1'b0);
        wait_acks(1);
        step(6);
        tests_run++;
        if (req_obs.size() != exp_req.size() || ack_obs.size() != 1) begin
            failed++;
            $display("FAIL fresh_counts: got reqs=%0d acks=%0d expected %0d and 1",
                     req_obs.size(), ack_obs.size(), exp_req.size());
        end
        while (exp_req.size() > 0 && req_obs.size() > 0) begin
            e = exp_req.pop_front(); o = req_obs.pop_front();
            tests_run++;
            if (o !== e) begin failed++; $display("FAIL fresh_req: got %h expected %h", o, e); end
        end
        if (ack_obs.size() > 0) begin
            ea = exp_ack.pop_front(); oa = ack_obs.pop_front();
            tests_run++;
            if (oa !== ea) begin failed++; $display("FAIL fresh_ack: got %h expected %h", oa, ea); end
        end
    endtask

    task automatic test_addr_wrap();
        logic [64:0] e, o;
        logic [A-1:0] rd_addrs[4];
        clear_logs();
        rd_addrs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        for (int k = 0; k < N; k++) preload(rd_addrs[k], 32'hC0 + 32'(k));
        issue_noc(1'b0, 32'hFFFF_FFF8, 32'h300, 3'd1, 8'h01, 1'b0);
        wait_acks(1);
        step(6);
        tests_run++;
        if (req_obs.size() != 2 * N) begin
            failed++;
            $display("FAIL wrap_req_count: got %0d expected %0d", req_obs.size(), 2 * N);
        end else begin
            for (int k = 0; k < N; k++) begin
                tests_run++;
                if (req_obs[2 * k][63:32] !== rd_addrs[k]) begin
                    failed++;
                    $display("FAIL wrap_rd_addr[%0d]: got %h expected %h", k, req_obs[2 * k][63:32], rd_addrs[k]);
                end
            end
        end
        while (exp_req.size() > 0 && req_obs.size() > 0) begin
            e = exp_req.pop_front(); o = req_obs.pop_front();
            tests_run++;
            if (o !== e) begin failed++; $display("FAIL wrap_req: got %h expected %h", o, e); end
        end
    endtask

`ifdef DMA_DOMAIN_CHECK_EN
    task automatic test_domain_check();
        logic [64:0] e, o;
        logic [RESP_W:0] ea, oa;
        clear_logs();
        issue_noc(1'b0, 32'h100, 32'h8000, 3'd1, 8'h5A, 1'b1);
        wait_acks(1);
        step(6);
        tests_run++;
        if (req_obs.size() != 0 || ack_obs.size() != 1) begin
            failed++;
            $display("FAIL dom_block: got reqs=%0d acks=%0d expected 0 and 1", req_obs.size(), ack_obs.size());
        end
        if (ack_obs.size() > 0) begin
            ea = exp_ack.pop_front(); oa = ack_obs.pop_front();
            tests_run++;
            if (oa !== ea) begin failed++; $display("FAIL dom_err_ack: got %h expected %h", oa, ea); end
        end
        clear_logs();
        issue_noc(1'b1, 32'h100, 32'h8000, 3'd1, 8'h5A, 1'b0);
        wait_acks(1);
        step(6);
        tests_run++;
        if (req_obs.size() != exp_req.size()) begin
            failed++;
            $display("FAIL dom_allow_count: got %0d expected %0d", req_obs.size(), exp_req.size());
        end
        while (exp_req.size() > 0 && req_obs.size() > 0) begin
            e = exp_req.pop_front(); o = req_obs.pop_front();
            tests_run++;
            if (o !== e) begin failed++; $display("FAIL dom_allow_req: got %h expected %h", o, e); end
        end
    endtask
`endif

    initial begin
        dma_val = 1'b0; dma_domain = 1'b0; dma_src_addr = '0; dma_dest_addr = '0;
        dma_req_control = '0; dma_inst = 1'b0;
        dma_db_val = 1'b0; dma_db_domain = 1'b0; dma_db_src_addr = '0;
        dma_db_dest_addr = '0; dma_db_inst = 1'b0;
        mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
        test_reset();
        test_noc_copy();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_addr_wrap();
`ifdef DMA_DOMAIN_CHECK_EN
        test_domain_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
